// File: rtl/hazard_stall_unit_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit_if
// Groups the decode-stage operand/destination information, the redirect
// selects and the stall/bypass results exchanged between the pipeline
// (master) and the hazard stall unit (slave).
//
// Signals:
//   rs1_decode, rs2_decode            decode source registers
//   rs1_used_decode, rs2_used_decode  decode instruction reads rs1 / rs2
//   rd_decode                         decode destination register
//   regWrite_decode                   decode instruction writes rd
//   memRead_decode                    decode instruction is a load
//   next_PC_select_execute/memory1/memory2  non-zero = redirect in that stage
//   stall                             hold fetch/decode, bubble decode->execute
//   rs1_bypass_sel, rs2_bypass_sel    0 regfile, 1 EX, 2 MEM1, 3 MEM2, 4 WB
// ----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
    parameter int REG_SEL_BITS = 5
);
    logic [REG_SEL_BITS-1:0] rs1_decode;
    logic [REG_SEL_BITS-1:0] rs2_decode;
    logic                    rs1_used_decode;
    logic                    rs2_used_decode;
    logic [REG_SEL_BITS-1:0] rd_decode;
    logic                    regWrite_decode;
    logic                    memRead_decode;
    logic [1:0]              next_PC_select_execute;
    logic [1:0]              next_PC_select_memory1;
    logic [1:0]              next_PC_select_memory2;
    logic                    stall;
    logic [2:0]              rs1_bypass_sel;
    logic [2:0]              rs2_bypass_sel;

    // Pipeline side: supplies decode state, consumes stall/bypass.
    modport master (
        output rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode,
               rd_decode, regWrite_decode, memRead_decode,
               next_PC_select_execute, next_PC_select_memory1,
               next_PC_select_memory2,
        input  stall, rs1_bypass_sel, rs2_bypass_sel
    );

    // Hazard unit side.
    modport slave (
        input  rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode,
               rd_decode, regWrite_decode, memRead_decode,
               next_PC_select_execute, next_PC_select_memory1,
               next_PC_select_memory2,
        output stall, rs1_bypass_sel, rs2_bypass_sel
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit
// Stall and bypass generator for the 7-stage pipeline. Shadows the
// destination state {rd, regWrite, memRead} of the EX, MEM1, MEM2 and WB
// stages and, from that plus the decode-stage instruction, produces a
// load-use stall and per-operand bypass selects.
//
// Ports:
//   clock        sole clock
//   reset        asynchronous reset, active-low
//   hz           hazard_stall_unit_if.slave (decode info, redirects,
//                stall and bypass selects)
//   stall_count  32-bit saturating count of stalled cycles; exists only
//                when the macro HAZARD_PERF_CNT_EN is defined
//
// Optional feature macro: HAZARD_PERF_CNT_EN
// ----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int REG_SEL_BITS = 5,
    parameter int STAGES       = 4
) (
    input  logic               clock,
    input  logic               reset,
    hazard_stall_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    // Shadow index 0 is EX, 1 MEM1, 2 MEM2, 3 WB.
    logic [REG_SEL_BITS-1:0] rd_r [STAGES];
    logic [STAGES-1:0]       reg_write_r;
    logic [STAGES-1:0]       mem_read_r;

    logic                    flush_s;
    logic                    hazard_s;
    logic                    stall_s;
    logic [STAGES-1:0]       rs1_match_s;
    logic [STAGES-1:0]       rs2_match_s;
    logic [2:0]              rs1_sel_s;
    logic [2:0]              rs2_sel_s;

    // An entry supplies an operand only if it writes a non-zero register
    // equal to the operand and the operand is actually read.
    function automatic logic entry_match(
        input logic                    used,
        input logic [REG_SEL_BITS-1:0] rs,
        input logic [REG_SEL_BITS-1:0] rd,
        input logic                    wr
    );
        return used && wr && (rd != {REG_SEL_BITS{1'b0}}) && (rd == rs);
    endfunction

    // Youngest match wins; a load that is not yet in WB yields regfile (0)
    // since its data does not exist yet and the stall holds the reader.
    function automatic logic [2:0] pick_sel(
        input logic [STAGES-1:0] match,
        input logic [STAGES-1:0] is_load
    );
        logic [2:0] sel;
        sel = 3'd0;
        if (match[0]) begin
            sel = is_load[0] ? 3'd0 : 3'd1;
        end else if (match[1]) begin
            sel = is_load[1] ? 3'd0 : 3'd2;
        end else if (match[2]) begin
            sel = is_load[2] ? 3'd0 : 3'd3;
        end else if (match[3]) begin
            sel = 3'd4;
        end else begin
            sel = 3'd0;
        end
        return sel;
    endfunction

    // Per-entry operand match vectors.
    always_comb begin
        rs1_match_s = {STAGES{1'b0}};
        rs2_match_s = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            rs1_match_s[i] = entry_match(hz.rs1_used_decode, hz.rs1_decode,
                                         rd_r[i], reg_write_r[i]);
            rs2_match_s[i] = entry_match(hz.rs2_used_decode, hz.rs2_decode,
                                         rd_r[i], reg_write_r[i]);
        end
    end

    // Flush, load-use hazard, stall and bypass selects.
    always_comb begin
        flush_s  = (hz.next_PC_select_execute != 2'd0) ||
                   (hz.next_PC_select_memory1 != 2'd0) ||
                   (hz.next_PC_select_memory2 != 2'd0);
        // Loads in EX/MEM1/MEM2 are not forwardable; WB is excluded by mask.
        hazard_s = |((rs1_match_s | rs2_match_s) & mem_read_r &
                     {1'b0, {(STAGES-1){1'b1}}});
        // A wrong-path instruction never needs to wait for data.
        stall_s   = hazard_s && !flush_s;
        rs1_sel_s = pick_sel(rs1_match_s, mem_read_r);
        rs2_sel_s = pick_sel(rs2_match_s, mem_read_r);
    end

    assign hz.stall          = stall_s;
    assign hz.rs1_bypass_sel = rs1_sel_s;
    assign hz.rs2_bypass_sel = rs2_sel_s;

    // Shadow shift register mirroring the pipe registers' bubble/flush rules.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                rd_r[i] <= {REG_SEL_BITS{1'b0}};
            end
            reg_write_r <= {STAGES{1'b0}};
            mem_read_r  <= {STAGES{1'b0}};
        end else begin
            if (flush_s || stall_s) begin
                rd_r[0]        <= {REG_SEL_BITS{1'b0}};
                reg_write_r[0] <= 1'b0;
                mem_read_r[0]  <= 1'b0;
            end else begin
                rd_r[0]        <= hz.rd_decode;
                reg_write_r[0] <= hz.regWrite_decode;
                mem_read_r[0]  <= hz.memRead_decode;
            end
            for (int i = 1; i < STAGES; i++) begin
                rd_r[i]        <= rd_r[i-1];
                reg_write_r[i] <= reg_write_r[i-1];
                mem_read_r[i]  <= mem_read_r[i-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_r;

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 32'd0;
        end else if (stall_s && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Self-checking bench for hazard_stall_unit. Expected {stall, rs1 sel,
// rs2 sel} triples are pushed to a scoreboard queue when the decode
// instruction is driven and popped at the falling edge of the same cycle.
// Build with HAZARD_PERF_CNT_EN defined to also check stall_count.
// ----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       stall;
        logic [2:0] s1;
        logic [2:0] s2;
    } exp_t;

    logic clock;
    logic reset;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count;
`endif

    hazard_stall_unit_if #(.REG_SEL_BITS(5)) hif ();

    hazard_stall_unit #(.REG_SEL_BITS(5), .STAGES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .hz          (hif.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    exp_t        sb_q [$];
    exp_t        e;
    exp_t        got;
    int          vectors;
    int          miscompares;
    logic [31:0] exp_count;
    logic        last_exp_stall;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic wr, input logic mr,
                         input logic [1:0] pex, input logic [1:0] pm1,
                         input logic [1:0] pm2);
        hif.rs1_decode             = rs1;
        hif.rs2_decode             = rs2;
        hif.rs1_used_decode        = u1;
        hif.rs2_used_decode        = u2;
        hif.rd_decode              = rd;
        hif.regWrite_decode        = wr;
        hif.memRead_decode         = mr;
        hif.next_PC_select_execute = pex;
        hif.next_PC_select_memory1 = pm1;
        hif.next_PC_select_memory2 = pm2;
    endtask

    task automatic drive_nop();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    endtask

    // Advance past the next rising edge; the counter model follows stall.
    task automatic next_cycle();
        if (last_exp_stall) exp_count = exp_count + 32'd1;
        last_exp_stall = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        drive_nop();
        for (int k = 0; k < 4; k++) next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
        #3;
        for (int c = 0; c < 2; c++) begin
            sb_q.push_back({1'b0, 3'd0, 3'd0});
            if (c == 1) @(negedge clock);
            got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
            e = sb_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset c=%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                         c, got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (stall_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", stall_count);
        end
`endif
        drive_nop();
        #2 reset = 1'b1;
        exp_count = 32'd0;
        last_exp_stall = 1'b0;
        next_cycle();
    endtask

    // Load x5 followed at distance d by add x6,x5,x1.
    task automatic test_load_use();
        for (int d = 1; d <= 4; d++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
            for (int c = 0; c < d; c++) begin
                if (c > 0) drive_nop();
                sb_q.push_back({1'b0, 3'd0, 3'd0});
                @(negedge clock);
                got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
                e = sb_q.pop_front();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL load_use_pre d=%0d c=%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                             d, c, got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
                end
                last_exp_stall = e.stall;
                next_cycle();
            end
            drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
            for (int c = 0; c <= 4 - d; c++) begin
                if (c < 4 - d) sb_q.push_back({1'b1, 3'd0, 3'd0});
                else           sb_q.push_back({1'b0, 3'd4, 3'd0});
                @(negedge clock);
                got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
                e = sb_q.pop_front();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL load_use d=%0d c=%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                             d, c, got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
                end
`ifdef HAZARD_PERF_CNT_EN
                if (c == 4 - d) begin
                    vectors++;
                    if (stall_count !== exp_count) begin
                        miscompares++;
                        $display("FAIL stall_count d=%0d: got %0d expected %0d",
                                 d, stall_count, exp_count);
                    end
                end
`endif
                last_exp_stall = e.stall;
                next_cycle();
            end
            drain();
        end
    endtask

    // ALU producer of x7 at distance d, reader sub x8,x7,x7.
    task automatic test_alu_forward();
        for (int d = 1; d <= 4; d++) begin
            drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
            next_cycle();
            for (int c = 1; c < d; c++) begin
                drive_nop();
                next_cycle();
            end
            drive(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
            sb_q.push_back({1'b0, d[2:0], d[2:0]});
            @(negedge clock);
            got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
            e = sb_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL alu_forward d=%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                         d, got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
            end
            next_cycle();
            if (d == 1) begin
                drive(5'd7, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
                sb_q.push_back({1'b0, 3'd2, 3'd0});
                @(negedge clock);
                got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
                e = sb_q.pop_front();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL alu_next_cycle: got %b/%0d/%0d expected %b/%0d/%0d",
                             got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
                end
                next_cycle();
            end
            drain();
        end
    endtask

    // x7 written in both MEM1 and WB when the reader decodes.
    task automatic test_youngest();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        next_cycle();
        drive_nop();
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        next_cycle();
        drive_nop();
        next_cycle();
        drive(5'd7, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        sb_q.push_back({1'b0, 3'd2, 3'd2});
        @(negedge clock);
        got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
        e = sb_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL youngest: got %b/%0d/%0d expected %b/%0d/%0d",
                     got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
        end
        next_cycle();
        drain();
    endtask

    // Load to x0 never creates a dependency.
    task automatic test_x0();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
        next_cycle();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        sb_q.push_back({1'b0, 3'd0, 3'd0});
        @(negedge clock);
        got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
        e = sb_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL x0: got %b/%0d/%0d expected %b/%0d/%0d",
                     got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
        end
        next_cycle();
        drain();
    endtask

    // Hazard coinciding with a MEM1 redirect: no stall, EX bubbled.
    task automatic test_flush();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0);
                sb_q.push_back({1'b0, 3'd0, 3'd0});
            end else begin
                // Reads x6: a non-bubbled EX entry would forward with select 1.
                drive(5'd6, 5'd6, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
                sb_q.push_back({1'b0, 3'd0, 3'd0});
            end
            @(negedge clock);
            got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
            e = sb_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL flush c=%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                         c, got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
            end
            next_cycle();
        end
        drain();
    endtask

    // Reset pulsed during a load-use stall.
    task automatic test_reset_mid_stall();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
        next_cycle();
        drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            if (c == 0) sb_q.push_back({1'b1, 3'd0, 3'd0});
            else        sb_q.push_back({1'b0, 3'd0, 3'd0});
            if (c == 0) @(negedge clock);
            if (c == 1) begin
                #1 reset = 1'b0;
                #1;
            end
            if (c == 2) begin
                #2 reset = 1'b1;
                exp_count = 32'd0;
                last_exp_stall = 1'b0;
                next_cycle();
                @(negedge clock);
            end
            got = {hif.stall, hif.rs1_bypass_sel, hif.rs2_bypass_sel};
            e = sb_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid_stall c=%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                         c, got.stall, got.s1, got.s2, e.stall, e.s1, e.s2);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (stall_count !== exp_count) begin
            miscompares++;
            $display("FAIL reset_mid_stall_count: got %0d expected %0d",
                     stall_count, exp_count);
        end
`endif
        next_cycle();
        drain();
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        exp_count      = 32'd0;
        last_exp_stall = 1'b0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_youngest();
        test_x0();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and bypass generator for the 7-stage stall/bypass pipeline: it is the source of the `stall` input consumed by the decode-to-execute pipe register. It shadows destination-register state for the execute, memory1, memory2 and writeback stages, applying the same bubble/flush rules as the pipe registers. From that state it drives a load-use stall and per-operand bypass selects for the instruction currently in decode.

## Interface
Parameters:
- `REG_SEL_BITS`, 5: register index width.
- `STAGES`, 4: shadow depth (EX, MEM1, MEM2, WB); fixed at 4 for this pipeline.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous reset, active-low.
- `rs1_decode`  in  5  decode-stage source register 1.
- `rs2_decode`  in  5  decode-stage source register 2.
- `rs1_used_decode`  in  1  decode instruction reads rs1.
- `rs2_used_decode`  in  1  decode instruction reads rs2.
- `rd_decode`  in  5  decode-stage destination.
- `regWrite_decode`  in  1  decode instruction writes rd.
- `memRead_decode`  in  1  decode instruction is a load.
- `next_PC_select_execute`  in  2  non-zero means redirect in EX.
- `next_PC_select_memory1`  in  2  non-zero means redirect in MEM1.
- `next_PC_select_memory2`  in  2  non-zero means redirect in MEM2.
- `stall`  out  1  hold fetch/decode and bubble the decode-to-execute pipe.
- `rs1_bypass_sel`  out  3  0 = regfile, 1 = EX, 2 = MEM1, 3 = MEM2, 4 = WB.
- `rs2_bypass_sel`  out  3  same encoding as `rs1_bypass_sel`.
- `stall_count`  out  32  present only with `HAZARD_PERF_CNT_EN`.

## Operation
- Each shadow entry holds `{rd, regWrite, memRead}`. Every cycle the entries shift: EX←decode, MEM1←EX, MEM2←MEM1, WB←MEM2.
- `flush` = any `next_PC_select_*` non-zero.
- EX entry loads a bubble `{0,0,0}` when `flush` or `stall` is true; otherwise it loads the decode values.
- An entry matches operand `rsN` when all of the following hold: `rsN_used_decode`, entry `regWrite`, entry `rd != 0`, entry `rd == rsN_decode`.
- `hazard` = a match with a `memRead=1` entry in EX, MEM1 or MEM2. Load data is forwardable only from WB.
- `stall = hazard && !flush`. A wrong-path instruction never stalls.
- Bypass select picks the youngest matching entry, priority EX > MEM1 > MEM2 > WB. The select is 0 when no entry matches, or when the youngest match is a load not yet in WB; `stall` covers the latter case.
- `stall`, `rs1_bypass_sel` and `rs2_bypass_sel` are combinational from shadow state and decode inputs. There are no registered outputs besides the shadow entries and the counter.

## Timing
- Reset (asynchronous, `reset`=0): all shadow entries `{0,0,0}`, `stall`=0, both selects 0, `stall_count`=0. Outputs stay at these values until the first rising edge after `reset` returns to 1.
- Outputs are valid in the same cycle as the decode inputs; the decode-to-execute pipe samples them at the next rising edge.
- Load-use distance 1: `stall` is high for 3 consecutive cycles while the load moves EX→MEM1→MEM2. In the 4th cycle the load is in WB, `stall`=0 and the select for the matching operand is 4.
- Load-use distance 2: 2 stall cycles. Distance 3: 1 stall cycle. Distance ≥4: no stall.
- ALU producer at distance 1/2/3/4: no stall, select 1/2/3/4 respectively.
- Flush and hazard in the same cycle: `stall`=0 and the EX entry is bubbled.
- Reset asserted mid-stall: `stall` drops immediately and asynchronously. No stale hazard remains after release.
- `rs1_decode == rs2_decode`: both selects are identical.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_count` port exists. The counter increments on each rising edge where `stall`=1, saturates at 32'hFFFFFFFF, and is cleared only by reset.
- `HAZARD_PERF_CNT_EN` undefined: the port and the counter are absent. Stall and bypass behaviour is identical in both builds.

## Test plan
- Load x5 (`rd`=5, `memRead`=1), then `add x6,x5,x1`: `stall`=1 for exactly 3 cycles, then `rs1_bypass_sel`=4 and `stall`=0. With the macro defined, `stall_count`=3.
- `addi x7,x0,1`, then `sub x8,x7,x7`: no stall, `rs1_bypass_sel`=`rs2_bypass_sel`=1. One cycle later with an unrelated instruction in decode that reads x7, select is 2.
- Writes to x7 in both MEM1 and WB, decode reads x7: select = 2 (youngest wins).
- Load with `rd`=0 followed by a reader of x0: `stall`=0, select 0.
- Load x5 followed by a reader of x5, with `next_PC_select_memory1`=2'b01 in the same cycle: `stall`=0 and the EX shadow entry becomes `{0,0,0}`.
- Load-use stall in progress, `reset` pulsed low for half a cycle: `stall`=0 immediately. After release, the same decode reader gets `stall`=0 and select 0.
